// File: rtl/i2s_rx_deser_if.sv
// i2s_rx_deser_if: serial-in / word-out bundle for the I2S receiver.
//   lrck, sdin  : codec word select and serial data (master drives)
//   err_clr     : synchronous clear of the sticky framing error (master drives)
//   data        : received word, MSB-aligned (receiver drives)
//   l_vld/r_vld : one-cycle strobes qualifying data as left/right (receiver drives)
//   frame_err   : sticky framing error flag (receiver drives)
interface i2s_rx_deser_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  lrck;
  logic                  sdin;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data;
  logic                  l_vld;
  logic                  r_vld;
  logic                  frame_err;

  modport master (
    output lrck, sdin, err_clr,
    input  data, l_vld, r_vld, frame_err
  );

  modport slave (
    input  lrck, sdin, err_clr,
    output data, l_vld, r_vld, frame_err
  );
endinterface

// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: I2S serial-to-parallel receiver clocked by the codec bit clock.
// Tracks lrck framing, emits one MSB-aligned word per channel slot with a
// one-cycle l_vld/r_vld strobe, and flags short slots / lost lrck in a sticky
// frame_err.
//   sck   : bit clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : i2s_rx_deser_if.slave (lrck, sdin, err_clr in; data, l_vld,
//           r_vld, frame_err out)
// Parameters: DATA_WIDTH (>= 2) output word width, MAX_SLOT (>= DATA_WIDTH)
// longest legal slot in sck cycles.
// Build option: I2S_RX_LJ_MODE_EN selects left-justified timing (MSB on the
// lrck edge); undefined gives standard I2S one-bit-delay timing.
module i2s_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_SLOT   = 32
) (
  input logic           sck,
  input logic           rst_n,
  i2s_rx_deser_if.slave bus
);
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;

  // cnt must reach MAX_SLOT, and slot_len one more than that
  localparam int CW = $clog2(MAX_SLOT + 2);
  localparam logic [CW-1:0] DW_C  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_SLOT);

  logic [1:0]            state;
  logic                  lrck_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  l_q, r_q, err_q;

  logic                  e_evt, timeout, short_slot, err_set;
  logic [CW-1:0]         slot_len, shamt, cnt_e;
  logic [DATA_WIDTH-1:0] sr_shift, cap, word, sr_e;

  assign e_evt    = bus.lrck != lrck_q;
  assign sr_shift = {sr[DATA_WIDTH-2:0], bus.sdin};

`ifdef I2S_RX_LJ_MODE_EN
  // The edge bit opens the new slot, so the ending word is sr alone and the
  // new slot starts with one bit already captured.
  assign slot_len = cnt;
  assign cap      = sr;
  assign cnt_e    = CW'(1);
  assign sr_e     = {{(DATA_WIDTH-1){1'b0}}, bus.sdin};
`else
  // The edge bit is the LSB of the ending slot; keep it only if there is room.
  assign slot_len = cnt + CW'(1);
  assign cap      = (cnt < DW_C) ? sr_shift : sr;
  assign cnt_e    = '0;
  assign sr_e     = '0;
`endif

  // cap holds min(slot_len, DATA_WIDTH) bits right-aligned; left-align them.
  assign short_slot = slot_len < DW_C;
  assign shamt      = short_slot ? DW_C - slot_len : '0;
  assign word       = cap << shamt;
  assign timeout    = cnt >= MAX_C;
  assign err_set    = (state == ST_RECV) && (e_evt ? short_slot : timeout);

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      lrck_q <= 1'b0;
      cnt    <= '0;
      sr     <= '0;
      data_q <= '0;
      l_q    <= 1'b0;
      r_q    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      lrck_q <= bus.lrck;
      l_q    <= 1'b0;
      r_q    <= 1'b0;
      // set wins over a simultaneous clear
      if (err_set)          err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
      case (state)
        // one cycle to load lrck_q so reset never looks like an edge
        ST_INIT: state <= ST_SYNC;
        // first slot after (re)sync is partial: align on the edge, emit nothing
        ST_SYNC: if (e_evt) begin
          state <= ST_RECV;
          cnt   <= cnt_e;
          sr    <= sr_e;
        end
        ST_RECV: begin
          if (e_evt) begin
            data_q <= word;
            l_q    <= ~lrck_q;
            r_q    <= lrck_q;
            cnt    <= cnt_e;
            sr     <= sr_e;
          end else if (timeout) begin
            state <= ST_SYNC;
            cnt   <= '0;
            sr    <= '0;
          end else begin
            if (cnt < DW_C) sr <= sr_shift;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.l_vld     = l_q;
  assign bus.r_vld     = r_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: three receivers (DATA_WIDTH 16/24/8, MAX_SLOT 32) share one
// serial stream. A slot-level reference model (bit queue per slot, words
// rebuilt arithmetically) predicts every output each cycle; directed steps add
// fixed-value checks for the key scenarios, then randomized slots follow.
module tb_i2s_rx_deser;
`ifdef I2S_RX_LJ_MODE_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif
  localparam int MAX_SLOT = 32;
  localparam int DWS [3] = '{16, 24, 8};

  logic sck = 1'b0;
  logic rst_n = 1'b0;
  logic lrck = 1'b1, sdin = 1'b0, clr = 1'b0;

  i2s_rx_deser_if #(.DATA_WIDTH(16)) if16 ();
  i2s_rx_deser_if #(.DATA_WIDTH(24)) if24 ();
  i2s_rx_deser_if #(.DATA_WIDTH(8))  if8 ();

  assign if16.lrck = lrck; assign if16.sdin = sdin; assign if16.err_clr = clr;
  assign if24.lrck = lrck; assign if24.sdin = sdin; assign if24.err_clr = clr;
  assign if8.lrck  = lrck; assign if8.sdin  = sdin; assign if8.err_clr  = clr;

  i2s_rx_deser #(.DATA_WIDTH(16), .MAX_SLOT(MAX_SLOT)) dut16 (.sck(sck), .rst_n(rst_n), .bus(if16));
  i2s_rx_deser #(.DATA_WIDTH(24), .MAX_SLOT(MAX_SLOT)) dut24 (.sck(sck), .rst_n(rst_n), .bus(if24));
  i2s_rx_deser #(.DATA_WIDTH(8),  .MAX_SLOT(MAX_SLOT)) dut8  (.sck(sck), .rst_n(rst_n), .bus(if8));

  initial forever #5 sck = ~sck;

  int n_cmp = 0, n_err = 0;

  // reference model state
  bit          fresh, locked, prev;
  bit          q[$];
  logic [31:0] exp_data [3];
  logic        exp_err  [3];
  logic        exp_l, exp_r;

  // observation bookkeeping
  logic [31:0] last_l [3], last_r [3];
  int          n_strb [3];
  logic        pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fresh = 1'b1; locked = 1'b0; prev = 1'b0; q.delete();
    exp_l = 1'b0; exp_r = 1'b0;
    for (int d = 0; d < 3; d++) begin exp_data[d] = '0; exp_err[d] = 1'b0; end
  endtask

  // One bit-clock tick of the receiver as described at slot level.
  task automatic model_tick(input logic lr, input logic sd, input logic c);
    bit set_err [3];
    int L;
    logic [31:0] w;
    exp_l = 1'b0; exp_r = 1'b0;
    for (int d = 0; d < 3; d++) set_err[d] = 1'b0;
    if (fresh) begin
      fresh = 1'b0;
      prev  = lr;
    end else begin
      if (!locked) begin
        if (lr != prev) begin
          locked = 1'b1;
          q.delete();
          if (LJ) q.push_back(sd);
        end
      end else if (lr == prev) begin
        q.push_back(sd);
        if (q.size() > MAX_SLOT) begin
          for (int d = 0; d < 3; d++) set_err[d] = 1'b1;
          locked = 1'b0;
          q.delete();
        end
      end else begin
        if (!LJ) q.push_back(sd);
        L = q.size();
        for (int d = 0; d < 3; d++) begin
          w = '0;
          for (int i = 0; i < DWS[d] && i < L; i++) w[DWS[d]-1-i] = q[i];
          exp_data[d] = w;
          if (L < DWS[d]) set_err[d] = 1'b1;
        end
        if (prev) exp_r = 1'b1; else exp_l = 1'b1;
        q.delete();
        if (LJ) q.push_back(sd);
      end
      prev = lr;
    end
    for (int d = 0; d < 3; d++)
      if (set_err[d]) exp_err[d] = 1'b1;
      else if (c)     exp_err[d] = 1'b0;
  endtask

  task automatic chk_dut(input int d, input logic [31:0] dat, input logic lv, input logic rv, input logic fe);
    chk($sformatf("data_w%0d", DWS[d]), dat, exp_data[d]);
    chk($sformatf("l_vld_w%0d", DWS[d]), 32'(lv), 32'(exp_l));
    chk($sformatf("r_vld_w%0d", DWS[d]), 32'(rv), 32'(exp_r));
    chk($sformatf("frame_err_w%0d", DWS[d]), 32'(fe), 32'(exp_err[d]));
    if (lv) last_l[d] = dat;
    if (rv) last_r[d] = dat;
    if (lv || rv) n_strb[d]++;
  endtask

  task automatic check_all();
    chk_dut(0, 32'(if16.data), if16.l_vld, if16.r_vld, if16.frame_err);
    chk_dut(1, 32'(if24.data), if24.l_vld, if24.r_vld, if24.frame_err);
    chk_dut(2, 32'(if8.data),  if8.l_vld,  if8.r_vld,  if8.frame_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_w16"}, {if16.frame_err, if16.r_vld, if16.l_vld, 13'd0, if16.data}, 32'd0);
    chk({tag, "_w24"}, {if24.frame_err, if24.r_vld, if24.l_vld, 5'd0,  if24.data}, 32'd0);
    chk({tag, "_w8"},  {if8.frame_err,  if8.r_vld,  if8.l_vld,  21'd0, if8.data},  32'd0);
  endtask

  // Called just after a negedge: drive, let the DUTs and model tick, check.
  task automatic step(input logic lr, input logic sd);
    lrck = lr; sdin = sd;
    @(posedge sck);
    model_tick(lr, sd, clr);
    @(negedge sck);
    check_all();
  endtask

  // One slot of n sck cycles on channel c carrying word w (MSB first) in
  // either I2S (one-bit delay) or left-justified wire format.
  task automatic send_slot(input logic c, input int n, input logic [63:0] w, input bit lj);
    logic b;
    for (int k = 0; k < n; k++) begin
      if (lj)         b = w[n-1-k];
      else if (k == 0) b = pend;
      else            b = w[n-k];
      step(c, b);
    end
    pend = w[0];
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk_zero("reset_async");
    @(negedge sck);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] w1;
    int          s0, n;
    logic        ch;
    model_reset();
    pend = 1'b0;
    for (int d = 0; d < 3; d++) begin last_l[d] = '0; last_r[d] = '0; n_strb[d] = 0; end
    @(negedge sck); @(negedge sck);
    chk_zero("reset_init");
    check_all();
    rst_n = 1'b1;

    // left 0xA5C3 / right 0x1234 after a partial right slot
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
    send_slot(1'b0, 16, 64'hA5C3, LJ);
    chk("no_emit_before_first_full", 32'(n_strb[0]), 32'd0);
    send_slot(1'b1, 16, 64'h1234, LJ);
    send_slot(1'b0, 16, 64'($urandom), LJ);
    chk("w16_left_a5c3", last_l[0], 32'hA5C3);
    chk("w16_right_1234", last_r[0], 32'h1234);

    // 12-bit slot on a 16-bit receiver: padded word plus error, then clear
    send_slot(1'b1, 12, 64'hABC, LJ);
    send_slot(1'b0, 16, 64'($urandom), LJ);
    chk("w16_short_word", last_r[0], 32'hABC0);
    chk("w16_short_err", 32'(if16.frame_err), 32'd1);
    clr = 1'b1;
    send_slot(1'b1, 16, 64'($urandom), LJ);
    send_slot(1'b0, 16, 64'($urandom), LJ);
    chk("w16_err_cleared", 32'(if16.frame_err), 32'd0);

    // 32-bit slots into the 24-bit receiver
    send_slot(1'b1, 32, 64'($urandom), LJ);
    clr = 1'b0;
    send_slot(1'b0, 32, 64'h123456FF, LJ);
    send_slot(1'b1, 32, 64'($urandom), LJ);
    chk("w24_long_word", last_l[1], 32'h123456);
    chk("w24_long_no_err", 32'(if24.frame_err), 32'd0);
    chk("w8_long_word", last_l[2], 32'h12);

    // lrck lost: slot keeps going past MAX_SLOT
    for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom_range(0, 1)));
    chk("timeout_err_w16", 32'(if16.frame_err), 32'd1);
    chk("timeout_err_w8", 32'(if8.frame_err), 32'd1);
    s0 = n_strb[0];
    send_slot(1'b0, 16, 64'($urandom), LJ);
    chk("timeout_first_edge_silent", 32'(n_strb[0] - s0), 32'd0);
    send_slot(1'b1, 16, 64'($urandom), LJ);
    chk("timeout_second_edge_emits", 32'(n_strb[0] - s0), 32'd1);

    // reset in the middle of a left slot
    send_slot(1'b0, 16, 64'($urandom), LJ);
    for (int i = 0; i < 8; i++) step(1'b0, 1'($urandom_range(0, 1)));
    do_reset();
    chk_zero("reset_mid_slot");
    s0 = n_strb[0];
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));
    w1 = 64'($urandom);
    send_slot(1'b1, 16, w1, LJ);
    chk("post_reset_sync_silent", 32'(n_strb[0] - s0), 32'd0);
    send_slot(1'b0, 16, 64'($urandom), LJ);
    chk("post_reset_first_word", last_r[0], {16'd0, w1[15:0]});
    send_slot(1'b1, 16, 64'($urandom), LJ);

    // left-justified wire format, 8-bit slots
    send_slot(1'b0, 8, 64'h5A, 1'b1);
    send_slot(1'b1, 8, 64'hC3, 1'b1);
    send_slot(1'b0, 8, 64'h0F, 1'b1);
    chk("w8_lj_stream", last_l[2], LJ ? 32'h5A : 32'hB5);

    // randomized slots, lengths spanning short, nominal and over-long
    ch = 1'b1;
    for (int s = 0; s < 60; s++) begin
      clr = ($urandom_range(0, 3) == 0);
      n = (s % 10 == 9) ? $urandom_range(MAX_SLOT, MAX_SLOT + 3) : $urandom_range(1, 24);
      send_slot(ch, n, {$urandom, $urandom}, LJ);
      ch = ~ch;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- Serial-to-parallel I2S receiver in the audio capture path, clocked by the codec bit clock sck.
- Samples sdin, tracks lrck framing and emits one parallel word per channel slot.
- Each word comes with a one-cycle l_vld or r_vld strobe, which drives the data/l_vld/r_vld inputs of the downstream channel-latch stage.
- Also detects malformed frames: short slots and a lost lrck.

Parameters:
- DATA_WIDTH, 8: output word width in bits; MSB first on the wire.
- MAX_SLOT, 32: maximum legal slot length in sck cycles; must be ≥ DATA_WIDTH.

Ports:
- sck  input  1  bit clock; all logic on posedge.
- rst_n  input  1  reset.
- lrck  input  1  word select: 0 = left, 1 = right.
- sdin  input  1  serial data.
- err_clr  input  1  synchronous clear of frame_err.
- data  output  DATA_WIDTH  received word, MSB-aligned.
- l_vld  output  1  one-cycle strobe: data holds a left word.
- r_vld  output  1  one-cycle strobe: data holds a right word.
- frame_err  output  1  sticky framing error flag.

Behaviour:
- Reset: rst_n is asynchronous and active-low.
  - All outputs are 0 in reset: data, l_vld, r_vld, frame_err.
  - State goes to INIT; lrck_q = 0, bit count cnt = 0, shift register sr = 0.
- States: INIT → SYNC → RECV.
  - INIT: lasts one posedge. It loads lrck_q from lrck and evaluates no edge. This prevents a false edge out of reset.
  - SYNC: on the first edge event E, go to RECV with cnt = 0. No word is emitted, because the first slot is partial.
  - RECV: normal reception.
- Edge event E: lrck != lrck_q at a posedge. lrck_q is updated every posedge.
- I2S timing (default mode):
  - The bit sampled on the E posedge is the LSB of the slot that is ending.
  - The MSB of the new slot is sampled on the following posedge.
- RECV, non-E posedge:
  - If cnt < DATA_WIDTH, shift sdin into the LSB of sr.
  - Increment cnt, saturating.
  - If cnt+1 > MAX_SLOT: set frame_err, go to SYNC, emit nothing.
- RECV, E posedge:
  - Capture the final bit as above. Slot length is L = cnt+1.
  - Emit data = captured bits left-aligned, zero-padded below. Bits beyond DATA_WIDTH are discarded.
  - Pulse l_vld if lrck_q was 0, r_vld if lrck_q was 1.
  - If L < DATA_WIDTH, set frame_err; the word is still emitted, padded.
  - Reset cnt = 0 and sr = 0.
- Latency:
  - data and the strobe are registered at the E posedge and are valid for exactly that one following cycle.
  - data holds its value until the next emit.
- Strobe exclusivity: l_vld and r_vld are never both 1, and are never high in INIT or SYNC.
- frame_err:
  - Sticky; err_clr clears it.
  - If an error and err_clr occur on the same posedge, set wins.
- Reset mid-slot: the partial word is dropped and INIT is re-entered. The next emit follows one full SYNC.

Optional Feature:
- Macro: I2S_RX_LJ_MODE_EN.
- Defined: left-justified timing.
  - The bit sampled on the E posedge is the MSB of the new slot, with no one-bit delay.
  - At E, L = cnt, and the word is emitted from sr excluding the current sdin.
  - sr is then loaded with sdin as its first bit, and cnt = 1.
  - Timeout, short-slot and strobe rules are unchanged.
- Undefined: standard I2S one-bit-delay timing as above.

Test Plan:
- Reset behaviour, DATA_WIDTH=16, 16-bit slots: left 0xA5C3 then right 0x1234 → l_vld with data=0xA5C3 at the lrck rise edge, then r_vld with 0x1234 at the fall edge; the first partial slot after reset emits nothing.
- DATA_WIDTH=24, 32-bit slots: left 0x123456FF → data=0x123456, no frame_err.
- DATA_WIDTH=16, 12-bit slot carrying 0xABC → data=0xABC0, frame_err=1; hold err_clr with no new error → frame_err=0.
- lrck stuck for MAX_SLOT+1 posedges → frame_err=1, no strobes; the first edge afterwards gives no strobe, the second emits a valid word.
- Assert rst_n low mid-left-slot, then release → all outputs 0; the first strobe appears only after a complete slot that follows a sync edge.
- With I2S_RX_LJ_MODE_EN, DATA_WIDTH=8, 8-bit slots, left 0x5A → l_vld, data=0x5A; the same stimulus without the macro yields 0xB4 plus the next bit.
